// File: rtl/upsample_pkg.sv
// rtl/upsample_pkg.sv - shared constants and helpers for the 2x upsampling sequencer
//
// Purpose: default geometry and widths, FSM state encodings, and helpers that
// derive output dimensions and line-buffer bank address width from the input
// geometry.
package upsample_pkg;

  localparam int IN_WIDTH_DEF  = 400;
  localparam int IN_HEIGHT_DEF = 300;
  localparam int DW_DEF        = 8;
  localparam int CW_DEF        = 10;

  // Controller FSM encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Output frame is twice the input frame in each direction
  function automatic int out_dim(input int in_dim);
    return 2 * in_dim;
  endfunction

  // Address width of one line-buffer bank (at least one bit)
  function automatic int bank_aw(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int OUT_WIDTH_DEF  = 2 * IN_WIDTH_DEF;
  localparam int OUT_HEIGHT_DEF = 2 * IN_HEIGHT_DEF;
  localparam int BANK_AW_DEF    = (IN_WIDTH_DEF > 1) ? $clog2(IN_WIDTH_DEF) : 1;

endpackage

// File: rtl/upsample_linebuf.sv
// rtl/upsample_linebuf.sv - two-bank ping-pong line buffer with registered read
//
// Purpose: holds two input rows. The bank select forms the address MSB.
// Ports:
//   clock, reset         - clock and synchronous active-low reset (read register only)
//   we, wbank, waddr,
//   wdata                - write port
//   re, rbank, raddr     - read request; data appears on rdata one cycle later
//   rdata                - registered read data, holds when re is low
module upsample_linebuf
  import upsample_pkg::*;
#(
  parameter int IN_WIDTH = IN_WIDTH_DEF,
  parameter int DW       = DW_DEF,
  parameter int AW       = bank_aw(IN_WIDTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic          wbank,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic          rbank,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 2 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Storage is never cleared; stale rows are simply overwritten by the next fill
  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[{wbank, waddr}] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[{rbank, raddr}];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/upsample_ctrl.sv
// rtl/upsample_ctrl.sv - 2x nearest-neighbour upsampling sequencer
//
// Purpose: pops IN_WIDTH x IN_HEIGHT pixels from a show-ahead FIFO into a
// ping-pong line buffer and replays each row twice with each pixel doubled.
// Ports:
//   clock, reset        - clock and synchronous active-low reset
//   fifo_valid/fifo_data- show-ahead FIFO head
//   fifo_read           - pop strobe (combinational)
//   dataout/validout    - upsampled pixel stream
//   rownum/colnum       - output coordinates of dataout
//   frame_done          - pulse with the last output pixel of the frame
//   busy                - first accepted pixel until frame_done
module upsample_ctrl
  import upsample_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int IN_HEIGHT = IN_HEIGHT_DEF,
  parameter int DW        = DW_DEF,
  parameter int CW        = CW_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          fifo_valid,
  input  logic [DW-1:0] fifo_data,
  output logic          fifo_read,
  output logic [DW-1:0] dataout,
  output logic          validout,
  output logic [CW-1:0] rownum,
  output logic [CW-1:0] colnum,
  output logic          frame_done,
  output logic          busy
);

  localparam int            AW        = bank_aw(IN_WIDTH);
  localparam logic [AW-1:0] WCOL_LAST = AW'(IN_WIDTH - 1);
  localparam logic [CW-1:0] OCOL_LAST = CW'(out_dim(IN_WIDTH) - 1);
  localparam logic [CW-1:0] OROW_LAST = CW'(out_dim(IN_HEIGHT) - 1);
  localparam logic [CW-1:0] ROWS_IN   = CW'(IN_HEIGHT);

  logic [1:0]    state_q, state_d;
  logic          arm_q;
  logic          wsel_q, wsel_d;
  logic          rsel_q, rsel_d;
  logic          pass_q, pass_d;
  logic [1:0]    full_q, full_d;
  logic [AW-1:0] wcol_q, wcol_d;
  logic [CW-1:0] in_rows_q, in_rows_d;
  logic [CW-1:0] ocol_q, ocol_d;
  logic [CW-1:0] orow_q, orow_d;
  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          valid_q, done_q;
  logic          busy_q, busy_d;
  logic          rd_en;
  logic          last_issue;
  logic [AW-1:0] rcol;

  // arm_q keeps the pop strobe low for the first cycle after reset even if
  // the FIFO already shows data.
  assign fifo_read  = arm_q && fifo_valid && !full_q[wsel_q] && (in_rows_q < ROWS_IN);
  assign rd_en      = full_q[rsel_q];
  assign last_issue = rd_en && (orow_q == OROW_LAST) && (ocol_q == OCOL_LAST);
  assign rcol       = AW'(ocol_q >> 1);

  always_comb begin
    state_d   = state_q;
    wsel_d    = wsel_q;
    rsel_d    = rsel_q;
    pass_d    = pass_q;
    full_d    = full_q;
    wcol_d    = wcol_q;
    in_rows_d = in_rows_q;
    ocol_d    = ocol_q;
    orow_d    = orow_q;
    row_d     = row_q;
    col_d     = col_q;
    busy_d    = busy_q;

    if (fifo_read) begin
      if (wcol_q == WCOL_LAST) begin
        full_d[wsel_q] = 1'b1;
        wsel_d         = ~wsel_q;
        wcol_d         = '0;
        in_rows_d      = in_rows_q + CW'(1);
      end else begin
        wcol_d = wcol_q + AW'(1);
      end
    end

    // Fill only targets a non-full bank and release only a full one, so the
    // two updates to full_d never hit the same bit.
    if (rd_en) begin
      row_d = orow_q;
      col_d = ocol_q;
      if (ocol_q == OCOL_LAST) begin
        ocol_d = '0;
        orow_d = orow_q + CW'(1);
        if (!pass_q) begin
          pass_d = 1'b1;
        end else begin
          full_d[rsel_q] = 1'b0;
          rsel_d         = ~rsel_q;
          pass_d         = 1'b0;
        end
      end else begin
        ocol_d = ocol_q + CW'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (fifo_read) begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (last_issue) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          orow_d  = '0;
        end
      end
      ST_DONE: begin
        // Input pacing reopens only once the frame_done pulse is out
        if (done_q) begin
          state_d   = ST_IDLE;
          in_rows_d = '0;
          wsel_d    = 1'b0;
          rsel_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      arm_q     <= 1'b0;
      wsel_q    <= 1'b0;
      rsel_q    <= 1'b0;
      pass_q    <= 1'b0;
      full_q    <= '0;
      wcol_q    <= '0;
      in_rows_q <= '0;
      ocol_q    <= '0;
      orow_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      arm_q     <= 1'b1;
      wsel_q    <= wsel_d;
      rsel_q    <= rsel_d;
      pass_q    <= pass_d;
      full_q    <= full_d;
      wcol_q    <= wcol_d;
      in_rows_q <= in_rows_d;
      ocol_q    <= ocol_d;
      orow_q    <= orow_d;
      row_q     <= row_d;
      col_q     <= col_d;
      valid_q   <= rd_en;
      done_q    <= last_issue;
      busy_q    <= busy_d;
    end
  end

  upsample_linebuf #(
    .IN_WIDTH (IN_WIDTH),
    .DW       (DW),
    .AW       (AW)
  ) u_linebuf (
    .clock (clock),
    .reset (reset),
    .we    (fifo_read),
    .wbank (wsel_q),
    .waddr (wcol_q),
    .wdata (fifo_data),
    .re    (rd_en),
    .rbank (rsel_q),
    .raddr (rcol),
    .rdata (dataout)
  );

  assign validout   = valid_q;
  assign rownum     = row_q;
  assign colnum     = col_q;
  assign frame_done = done_q;
  assign busy       = busy_q;

endmodule
